// File: rtl/dr_pkg.sv
// Shared types and widths for the data router command initiator.
// Imported by dr_win_cnt and data_router_ctrl.
package dr_pkg;

  typedef enum logic [1:0] {
    RR = 2'b00,
    BR = 2'b01,
    RP = 2'b10,
    NE = 2'b11
  } rpsel_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SLIDE,
    REFRESH,
    WAIT_BLK
  } state_t;

  localparam int BANK_W = 2;
  localparam int ROW_W  = 2;
  localparam int COL_W  = 28;

endpackage

// File: rtl/dr_win_cnt.sv
// Sliding-window walker: row is the inner index, col steps by STRIDE.
// Holds while en is low; wraps to (0,0) after the terminal count.
module dr_win_cnt
  import dr_pkg::*;
#(
  parameter int KSIZE  = 3,
  parameter int NSTEP  = 30,
  parameter int STRIDE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             last
);

  localparam logic [ROW_W-1:0] ROW_END = ROW_W'(KSIZE - 1);
  localparam logic [COL_W-1:0] COL_END = COL_W'((NSTEP - 1) * STRIDE);
  localparam logic [COL_W-1:0] STEP    = COL_W'(STRIDE);

  logic row_end;

  assign row_end = (row == ROW_END);
  assign last    = row_end && (col == COL_END);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row <= '0;
      col <= '0;
    end else if (clr || (en && last)) begin
      row <= '0;
      col <= '0;
    end else if (en) begin
      if (row_end) begin
        row <= '0;
        col <= col + STEP;
      end else begin
        row <= row + ROW_W'(1);
      end
    end
  end

endmodule

// File: rtl/data_router_ctrl.sv
// Command initiator for the data router: RR load, RP slide, BR refresh.
// Define DR_CTRL_ERRCHK_EN to add the sticky err output.
module data_router_ctrl
  import dr_pkg::*;
#(
  parameter int POY    = 3,
  parameter int BUFW   = 32,
  parameter int BUFH   = 3,
  parameter int KSIZE  = 3,
  parameter int STRIDE = 1,
  parameter int NBLK_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [NBLK_W-1:0] nblk,
  input  logic              stall,
  input  logic              blkend,
  output logic [BANK_W-1:0] bank,
  output logic [ROW_W-1:0]  row,
  output logic [COL_W-1:0]  col,
  output logic [1:0]        rpsel,
  output logic              cmd_valid,
  output logic              busy,
  output logic              done
`ifdef DR_CTRL_ERRCHK_EN
  ,
  output logic              err
`endif
);

  localparam int NSTEP = (BUFW - KSIZE) / STRIDE + 1;

  localparam logic [ROW_W-1:0]  LD_END  = ROW_W'(KSIZE - 1);
  localparam logic [BANK_W-1:0] BK_END  = BANK_W'(POY - 1);
  localparam logic [ROW_W-1:0]  RR_END  = ROW_W'(BUFH - 1);
  localparam logic [ROW_W-1:0]  RR_INIT = ROW_W'((BUFH > 1) ? 1 : 0);

  state_t              state;
  logic [NBLK_W-1:0]   nblk_l;
  logic [NBLK_W-1:0]   blk_cnt;
  logic [NBLK_W-1:0]   blk_nxt;
  logic [ROW_W-1:0]    ld_row;
  logic [BANK_W-1:0]   bk;
  logic [ROW_W-1:0]    ref_row;
  logic                armed;
  logic [ROW_W-1:0]    win_row;
  logic [COL_W-1:0]    win_col;
  logic                win_last;
  logic                win_en;
  logic                win_clr;

  assign blk_nxt = blk_cnt + NBLK_W'(1);
  assign win_en  = (state == SLIDE) && !stall;
  assign win_clr = (state == IDLE);

  dr_win_cnt #(
    .KSIZE (KSIZE),
    .NSTEP (NSTEP),
    .STRIDE(STRIDE)
  ) u_win (
    .clk (clk),
    .rst (rst),
    .clr (win_clr),
    .en  (win_en),
    .row (win_row),
    .col (win_col),
    .last(win_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      nblk_l    <= '0;
      blk_cnt   <= '0;
      ld_row    <= '0;
      bk        <= '0;
      ref_row   <= '0;
      armed     <= 1'b0;
      bank      <= '0;
      row       <= '0;
      col       <= '0;
      rpsel     <= RR;
      cmd_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      cmd_valid <= 1'b0;
      done      <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            nblk_l  <= (nblk == '0) ? NBLK_W'(1) : nblk;
            blk_cnt <= '0;
            ld_row  <= '0;
            bk      <= '0;
            ref_row <= RR_INIT;
            busy    <= 1'b1;
            state   <= LOAD;
          end
        end
        LOAD: begin
          if (!stall) begin
            cmd_valid <= 1'b1;
            rpsel     <= RR;
            bank      <= '0;
            row       <= ld_row;
            col       <= '0;
            if (ld_row == LD_END) begin
              ld_row <= '0;
              state  <= SLIDE;
            end else begin
              ld_row <= ld_row + ROW_W'(1);
            end
          end
        end
        SLIDE: begin
          if (!stall) begin
            cmd_valid <= 1'b1;
            rpsel     <= RP;
            bank      <= '0;
            row       <= win_row;
            col       <= win_col;
            if (win_last) state <= REFRESH;
          end
        end
        REFRESH: begin
          if (!stall) begin
            cmd_valid <= 1'b1;
            rpsel     <= BR;
            bank      <= bk;
            row       <= ref_row;
            col       <= '0;
            if (bk == BK_END) begin
              bk    <= '0;
              armed <= 1'b0;
              state <= WAIT_BLK;
            end else begin
              bk <= bk + BANK_W'(1);
            end
          end
        end
        WAIT_BLK: begin
          // the router cannot end a block while the last BR is on the bus
          if (!armed) begin
            armed <= 1'b1;
          end else if (blkend) begin
            if (blk_nxt == nblk_l) begin
              blk_cnt <= '0;
              ref_row <= '0;
              bank    <= '0;
              row     <= '0;
              col     <= '0;
              rpsel   <= RR;
              busy    <= 1'b0;
              done    <= 1'b1;
              state   <= IDLE;
            end else begin
              blk_cnt <= blk_nxt;
              ref_row <= (ref_row == RR_END) ? '0 : ref_row + ROW_W'(1);
              state   <= LOAD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DR_CTRL_ERRCHK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if ((blkend && state != WAIT_BLK) || (start && busy)) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_data_router_ctrl.sv
// Directed bench for data_router_ctrl: default build plus a STRIDE=2 copy.
// Valid commands are captured at negedge and compared to a spec-built list.
module tb_data_router_ctrl;
  import dr_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, stall, blkend;
  logic        start2, blkend2;
  logic        stall2;
  logic [7:0]  nblk, nblk2;

  logic [1:0]  bank_a, row_a, rpsel_a;
  logic [27:0] col_a;
  logic        cv_a, busy_a, done_a;
  logic [1:0]  bank_b, row_b, rpsel_b;
  logic [27:0] col_b;
  logic        cv_b, busy_b, done_b;
`ifdef DR_CTRL_ERRCHK_EN
  logic        err_a, err_b;
`endif

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  logic [33:0] q[$];
  logic [33:0] e[$];

  always #5 clk = ~clk;

  data_router_ctrl u_a (
    .clk(clk), .rst(rst), .start(start), .nblk(nblk),
    .stall(stall), .blkend(blkend),
    .bank(bank_a), .row(row_a), .col(col_a), .rpsel(rpsel_a),
    .cmd_valid(cv_a), .busy(busy_a), .done(done_a)
`ifdef DR_CTRL_ERRCHK_EN
    , .err(err_a)
`endif
  );

  data_router_ctrl #(.STRIDE(2)) u_b (
    .clk(clk), .rst(rst), .start(start2), .nblk(nblk2),
    .stall(stall2), .blkend(blkend2),
    .bank(bank_b), .row(row_b), .col(col_b), .rpsel(rpsel_b),
    .cmd_valid(cv_b), .busy(busy_b), .done(done_b)
`ifdef DR_CTRL_ERRCHK_EN
    , .err(err_b)
`endif
  );

  function automatic logic [33:0] norm(input logic [1:0] rp,
                                       input logic [1:0] bk,
                                       input logic [1:0] rw,
                                       input logic [27:0] cl);
    return {rp, (rp == BR) ? bk : 2'b00, rw, (rp == RP) ? cl : 28'd0};
  endfunction

  always @(negedge clk) begin
    if (cv_a) q.push_back(norm(rpsel_a, bank_a, row_a, col_a));
    if (cv_b) q.push_back(norm(rpsel_b, bank_b, row_b, col_b));
    if (done_a) done_cnt++;
    if (done_b) done_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic exp_blk(input int stride, input int k);
    int nstep;
    nstep = (32 - 3) / stride + 1;
    for (int r = 0; r < 3; r++)
      e.push_back({RR, 2'b00, 2'(r), 28'd0});
    for (int s = 0; s < nstep; s++)
      for (int r = 0; r < 3; r++)
        e.push_back({RP, 2'b00, 2'(r), 28'(s * stride)});
    for (int b = 0; b < 3; b++)
      e.push_back({BR, 2'(b), 2'((k + 1) % 3), 28'd0});
  endtask

  task automatic cmp_seq(input string tag);
    chk({tag, "_len"}, q.size(), e.size());
    for (int i = 0; i < q.size() && i < e.size(); i++)
      chk($sformatf("%s_cmd%0d", tag, i), q[i], e[i]);
    q.delete();
    e.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input bit sel, input logic [7:0] n);
    if (sel) begin
      nblk2 = n; start2 = 1'b1;
    end else begin
      nblk = n; start = 1'b1;
    end
    tick();
    start = 1'b0; start2 = 1'b0;
    chk("busy_on", sel ? busy_b : busy_a, 1'b1);
  endtask

  task automatic wait_cmds(input int n);
    for (int i = 0; i < 3000 && q.size() < n; i++) tick();
    chk("wait_cmds", q.size(), n);
  endtask

  task automatic wait_rp();
    for (int i = 0; i < 200 && !(cv_a && rpsel_a == RP); i++) tick();
    chk("wait_rp", rpsel_a, RP);
  endtask

  task automatic end_blk(input bit sel, input bit last);
    repeat (5) tick();
    chk("valid_low", sel ? cv_b : cv_a, 1'b0);
    if (sel) blkend2 = 1'b1;
    else blkend = 1'b1;
    tick();
    blkend = 1'b0; blkend2 = 1'b0;
    chk("done_rise", sel ? done_b : done_a, last);
    chk("busy_after", sel ? busy_b : busy_a, !last);
    tick();
    chk("done_fall", sel ? done_b : done_a, 1'b0);
  endtask

  initial begin
    rst = 1'b1; start = 0; stall = 0; blkend = 0;
    start2 = 0; blkend2 = 0; stall2 = 0;
    nblk = 8'd0; nblk2 = 8'd0;
    repeat (2) tick();
    chk("rst_outs", {bank_a, row_a, col_a, rpsel_a, cv_a, busy_a, done_a}, 0);
`ifdef DR_CTRL_ERRCHK_EN
    chk("rst_err", err_a, 1'b0);
`endif
    rst = 1'b0;
    tick();

    // single block, nblk=0 behaves as 1
    done_cnt = 0;
    go(0, 8'd0);
    exp_blk(1, 0);
    wait_cmds(96);
    end_blk(0, 1);
    chk("done_cnt1", done_cnt, 1);
    cmp_seq("one");

    // three blocks, refresh row advances mod BUFH
    done_cnt = 0;
    go(0, 8'd3);
    for (int k = 0; k < 3; k++) begin
      exp_blk(1, k);
      wait_cmds(96 * (k + 1));
      chk($sformatf("ref_row%0d", k), q[96 * k + 93][29:28], (k + 1) % 3);
      end_blk(0, k == 2);
      if (k < 2) chk("no_early_done", done_cnt, 0);
    end
    chk("done_cnt3", done_cnt, 1);
    cmp_seq("three");

    // stall four cycles with the window at s=10, r=1
    done_cnt = 0;
    go(0, 8'd1);
    exp_blk(1, 0);
    for (int i = 0; i < 200 && !(cv_a && rpsel_a == RP && row_a == 2'd0
                                 && col_a == 28'd10); i++) tick();
    chk("stall_at", col_a, 28'd10);
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_valid", cv_a, 1'b0);
    end
    stall = 1'b0;
    tick();
    chk("resume_valid", cv_a, 1'b1);
    chk("resume_cmd", norm(rpsel_a, bank_a, row_a, col_a),
        {RP, 2'b00, 2'd1, 28'd10});
    wait_cmds(96);
    end_blk(0, 1);
    cmp_seq("stall");

    // STRIDE=2 instance
    done_cnt = 0;
    go(1, 8'd1);
    exp_blk(2, 0);
    wait_cmds(51);
    end_blk(1, 1);
    chk("done_s2", done_cnt, 1);
    cmp_seq("s2");

    // stray start in LOAD and stray blkend in SLIDE are ignored
    done_cnt = 0;
    go(0, 8'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_hold", busy_a, 1'b1);
`ifdef DR_CTRL_ERRCHK_EN
    chk("err_start", err_a, 1'b1);
`endif
    wait_rp();
    blkend = 1'b1;
    tick();
    blkend = 1'b0;
    exp_blk(1, 0);
    wait_cmds(96);
    end_blk(0, 1);
    chk("glitch_done", done_cnt, 1);
`ifdef DR_CTRL_ERRCHK_EN
    chk("err_sticky", err_a, 1'b1);
`endif
    cmp_seq("glitch");

    // asynchronous reset in the middle of SLIDE
    done_cnt = 0;
    go(0, 8'd1);
    wait_rp();
    #2 rst = 1'b1;
    #1;
    chk("rst_async", {bank_a, row_a, col_a, rpsel_a, cv_a, busy_a, done_a}, 0);
`ifdef DR_CTRL_ERRCHK_EN
    chk("rst_err_clr", err_a, 1'b0);
`endif
    rst = 1'b0;
    q.delete();
    repeat (3) tick();
    chk("rst_no_done", done_cnt, 0);
    go(0, 8'd1);
    exp_blk(1, 0);
    wait_cmds(96);
    end_blk(0, 1);
    cmp_seq("restart");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_router_ctrl.md
Name: data_router_ctrl

Overview:
- Command initiator for the data router interface; drives bank/row/col/rpsel each cycle to pull line-buffer data into the PE array.
- Sequences one block per start: full-row load (RR), sliding-window pixel fetch (RP), per-bank row refresh (BR), then waits for the router's blkend pulse.
- Sits between the layer scheduler (start/nblk/done) and the router; never issues NE.

Parameters:
- POY, 3, bank count (row parallelism)
- BUFW, 32, line buffer width in pixels
- BUFH, 3, rows per bank
- KSIZE, 3, kernel size; KSIZE <= BUFH, KSIZE <= BUFW
- STRIDE, 1, window column step; 1 or 2
- NBLK_W, 8, width of block-count input

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  one-cycle pulse, accepted only in IDLE
- nblk  in  NBLK_W  blocks to run, sampled on start; 0 is treated as 1
- stall  in  1  downstream not ready; freezes sequencing
- blkend  in  1  router end-of-block pulse
- bank  out  2  target bank (BR)
- row  out  2  target row
- col  out  28  target column (RP)
- rpsel  out  2  00 RR, 01 BR, 10 RP
- cmd_valid  out  1  command fields valid this cycle
- busy  out  1  high from start accept to done
- done  out  1  one-cycle pulse after the last block

Behaviour:
- Reset, and IDLE: bank=0, row=0, col=0, rpsel=RR, cmd_valid=0, busy=0, done=0; all counters 0.
- Outputs are registered; a command appears the cycle after its state/counter value.
- NSTEP = (BUFW-KSIZE)/STRIDE+1, a localparam (30 at defaults).
- FSM states: IDLE, LOAD, SLIDE, REFRESH, WAIT_BLK.
- IDLE -> LOAD on start. Latch nblk (0 becomes 1); busy=1 the next cycle.
- LOAD: issue RR with row=r for r=0..KSIZE-1, then -> SLIDE.
- SLIDE: for s=0..NSTEP-1, and for each s r=0..KSIZE-1 (r inner), issue RP with row=r, col=s*STRIDE. Then -> REFRESH.
- REFRESH: issue BR with bank=b for b=0..POY-1, row=(blk_cnt+1) mod BUFH. Then -> WAIT_BLK.
- WAIT_BLK: cmd_valid=0; stay until blkend=1.
  - On blkend, blk_cnt+1. If blk_cnt+1 == nblk_latched: -> IDLE, done=1 for one cycle, busy falls in the same cycle.
  - Otherwise -> LOAD.
- Stall: while stall=1 in LOAD, SLIDE or REFRESH, all counters and the FSM hold, command fields hold, cmd_valid=0. The held command is reissued with cmd_valid=1 in the first cycle after stall falls, so no command is lost or duplicated.
- Stall in WAIT_BLK has no effect.
- blkend outside WAIT_BLK is ignored.
- blkend in the same cycle as entering WAIT_BLK is not counted. WAIT_BLK samples blkend from the cycle after entry.
- start while busy is ignored.
- Reset mid-operation: returns to IDLE immediately and asynchronously; no done pulse.
- Command cycles per block at defaults: 3 + 90 + 3 = 96.

Optional Feature:
- Macro DR_CTRL_ERRCHK_EN.
- When defined, adds output err (1 bit, sticky):
  - set on blkend outside WAIT_BLK;
  - set on start while busy;
  - cleared only by rst.
- When undefined, no err port and no checking logic; all other behaviour is identical.

Decomposition:
- Package dr_pkg:
  - rpsel_t enum (RR=2'b00, BR=2'b01, RP=2'b10, NE=2'b11);
  - FSM state enum;
  - width constants BANK_W=2, ROW_W=2, COL_W=28.
- One natural sub-module: dr_win_cnt, a nested row/column counter with stall-hold, terminal-count flag and STRIDE step, used by SLIDE. The top keeps the FSM and output registers.

Test Plan:
- Reset, then start with nblk=1 and no stall:
  - commands 1-3 are RR with rows 0,1,2;
  - RP follows, first (row0,col0) and last (row2,col29);
  - BR follows for banks 0,1,2 at row 1;
  - cmd_valid drops; blkend 5 cycles later gives done exactly one cycle later; total valid commands = 96.
- nblk=3 with blkend returned each block:
  - REFRESH rows are 1, 2, 0 in successive blocks;
  - exactly one done, after the 3rd blkend.
- stall held 4 cycles at SLIDE step s=10, r=1:
  - cmd_valid=0 for those 4 cycles;
  - the next valid command is RP(row1,col10) and the sequence continues with no gaps or repeats.
- STRIDE=2 build:
  - NSTEP=15; RP columns are 0,2,...,28;
  - 3+45+3 = 51 commands per block.
- Glitch/interrupt handling:
  - blkend pulsed during SLIDE and start pulsed during LOAD: both are ignored;
  - with DR_CTRL_ERRCHK_EN, err=1 after the first event and stays 1.
- Reset mid-SLIDE: rst asserted asynchronously between clock edges drives all outputs to their reset values immediately; the next start restarts from RR row 0.
